// File: rtl/washer_pkg.sv
// Shared timer-state encoding and default plant constants for the washer model.
package washer_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_WASH = 2'd1,
        T_SPIN = 2'd2
    } timer_state_t;

    localparam int DEF_LEVEL_MAX   = 8;
    localparam int DEF_WASH_CYCLES = 10;
    localparam int DEF_SPIN_CYCLES = 6;

endpackage

// File: rtl/washer_timer.sv
// Saturating cycle timer: counts while enabled, flags terminal count, clear wins over enable.
module washer_timer #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // Count holds at the terminal value until the owning phase ends or restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(CYCLES))) begin
            count <= count + CW'(1);
        end
    end

    // Gated by enable so the flag drops as soon as the phase is left.
    assign done = enable && (count == CW'(CYCLES));

endmodule

// File: rtl/washer_plant.sv
// Washing-machine plant model: water level, door, detergent, wash/spin timers.
// Optional sticky illegal-actuation detector enabled by defining WASHER_PLANT_FAULT_EN.
module washer_plant
    import washer_pkg::*;
#(
    parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
    parameter int WASH_CYCLES = DEF_WASH_CYCLES,
    parameter int SPIN_CYCLES = DEF_SPIN_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic door_close_req,
    input  logic door_open_req,
    input  logic fillvalve_on,
    input  logic drainvalve_on,
    input  logic motor_on,
    input  logic soap_wash,
    input  logic water_wash,
    input  logic doorlock,
    output logic doorclose,
    output logic filled,
    output logic drained,
    output logic detergent,
    output logic cycletime_out,
    output logic spintime_out,
    output logic fault
);

    localparam int LW = $clog2(LEVEL_MAX + 1);

    logic [LW-1:0] level;
    timer_state_t  state;
    timer_state_t  state_next;
    logic          water_wash_q;
    logic          phase_restart;
    logic          in_wash;
    logic          in_spin;

    // Level moves only when exactly one valve is open, saturating at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (fillvalve_on && !drainvalve_on && (level != LW'(LEVEL_MAX))) begin
            level <= level + LW'(1);
        end else if (drainvalve_on && !fillvalve_on && (level != '0)) begin
            level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filled  <= 1'b0;
            drained <= 1'b1;
        end else begin
            filled  <= (level == LW'(LEVEL_MAX));
            drained <= (level == '0);
        end
    end

    // A locked door cannot be opened; a close request always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            doorclose <= 1'b0;
        end else if (door_close_req) begin
            doorclose <= 1'b1;
        end else if (door_open_req && !doorlock) begin
            doorclose <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            detergent <= 1'b0;
        end else if (soap_wash && filled) begin
            detergent <= 1'b1;
        end else if (water_wash) begin
            detergent <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= T_IDLE;
            water_wash_q <= 1'b0;
        end else begin
            state        <= state_next;
            water_wash_q <= water_wash;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            T_IDLE: begin
                if (motor_on && (soap_wash || water_wash)) begin
                    state_next = T_WASH;
                end else if (motor_on && drainvalve_on && drained) begin
                    state_next = T_SPIN;
                end
            end
            T_WASH, T_SPIN: begin
                if (!motor_on) begin
                    state_next = T_IDLE;
                end
            end
            default: state_next = T_IDLE;
        endcase
    end

    // Entering the rinse (water) phase mid-wash restarts the wash time.
    assign in_wash       = (state == T_WASH);
    assign in_spin       = (state == T_SPIN);
    assign phase_restart = in_wash && water_wash && !water_wash_q;

    washer_timer #(.CYCLES(WASH_CYCLES)) u_wash_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (in_wash),
        .clear  (!in_wash || phase_restart),
        .done   (cycletime_out)
    );

    washer_timer #(.CYCLES(SPIN_CYCLES)) u_spin_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (in_spin),
        .clear  (!in_spin),
        .done   (spintime_out)
    );

`ifdef WASHER_PLANT_FAULT_EN
    // Sticky until reset so a transient misuse is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else if ((motor_on && !doorclose) ||
                     (fillvalve_on && drainvalve_on) ||
                     (!doorlock && (state != T_IDLE))) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_washer_plant.sv
// Directed scoreboard bench for washer_plant; expectations queued per step, checked after each edge.
module tb_washer_plant;

    logic clk;
    logic rst;
    logic door_close_req, door_open_req;
    logic fillvalve_on, drainvalve_on, motor_on, soap_wash, water_wash, doorlock;
    logic doorclose, filled, drained, detergent, cycletime_out, spintime_out, fault;

    localparam int S_DOOR  = 0;
    localparam int S_FILL  = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DET   = 3;
    localparam int S_CYC   = 4;
    localparam int S_SPIN  = 5;
    localparam int S_FAULT = 6;

`ifdef WASHER_PLANT_FAULT_EN
    localparam logic FEN = 1'b1;
`else
    localparam logic FEN = 1'b0;
`endif

    typedef struct {
        string tag;
        int    sig;
        logic  val;
    } exp_t;

    exp_t sb[$];
    int   testsRun;
    int   testsFailed;

    washer_plant dut (
        .clk            (clk),
        .rst            (rst),
        .door_close_req (door_close_req),
        .door_open_req  (door_open_req),
        .fillvalve_on   (fillvalve_on),
        .drainvalve_on  (drainvalve_on),
        .motor_on       (motor_on),
        .soap_wash      (soap_wash),
        .water_wash     (water_wash),
        .doorlock       (doorlock),
        .doorclose      (doorclose),
        .filled         (filled),
        .drained        (drained),
        .detergent      (detergent),
        .cycletime_out  (cycletime_out),
        .spintime_out   (spintime_out),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic outVal(input int sig);
        case (sig)
            S_DOOR:  return doorclose;
            S_FILL:  return filled;
            S_DRAIN: return drained;
            S_DET:   return detergent;
            S_CYC:   return cycletime_out;
            S_SPIN:  return spintime_out;
            default: return fault;
        endcase
    endfunction

    task automatic applyStimulus(input logic fill, input logic drain, input logic motor,
                                 input logic soap, input logic water, input logic lock,
                                 input logic closeReq, input logic openReq);
        fillvalve_on   = fill;
        drainvalve_on  = drain;
        motor_on       = motor;
        soap_wash      = soap;
        water_wash     = water;
        doorlock       = lock;
        door_close_req = closeReq;
        door_open_req  = openReq;
    endtask

    task automatic expect1(input string tag, input int sig, input logic val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        logic obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = outVal(e.sig);
            testsRun++;
            assert (obs === e.val)
            else begin
                testsFailed++;
                $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        expect1("rst_door", S_DOOR, 1'b0);
        expect1("rst_filled", S_FILL, 1'b0);
        expect1("rst_drained", S_DRAIN, 1'b1);
        expect1("rst_det", S_DET, 1'b0);
        expect1("rst_cyc", S_CYC, 1'b0);
        expect1("rst_spin", S_SPIN, 1'b0);
        expect1("rst_fault", S_FAULT, 1'b0);
        checkOutput();

        // Fill from empty, run past saturation
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            expect1($sformatf("fill_filled_%0d", k), S_FILL, (k >= 9));
            expect1($sformatf("fill_drained_%0d", k), S_DRAIN, (k < 2));
            tick();
            checkOutput();
        end

        // Door handling
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        expect1("door_close", S_DOOR, 1'b1);
        tick();
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        expect1("door_open_locked", S_DOOR, 1'b1);
        tick();
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        expect1("door_open_unlocked", S_DOOR, 1'b0);
        tick();
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        expect1("door_both_req", S_DOOR, 1'b1);
        tick();
        checkOutput();

        // Soap wash to timeout
        applyStimulus(0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) expect1("wash_detergent", S_DET, 1'b1);
            expect1($sformatf("wash_cyc_%0d", k), S_CYC, (k >= 11));
            tick();
            checkOutput();
        end

        // Rinse phase restarts the wash timer
        applyStimulus(0, 0, 1, 0, 1, 1, 0, 0);
        for (int j = 1; j <= 11; j++) begin
            if (j == 1) expect1("rinse_det_clear", S_DET, 1'b0);
            expect1($sformatf("rinse_cyc_%0d", j), S_CYC, (j == 11));
            tick();
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        expect1("motor_off_cyc", S_CYC, 1'b0);
        tick();
        checkOutput();

        // Reset in the middle of a wash
        applyStimulus(0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            expect1($sformatf("midwash_cyc_%0d", k), S_CYC, 1'b0);
            tick();
            checkOutput();
        end
        rst = 1'b0;
        #2;
        expect1("midrst_cyc", S_CYC, 1'b0);
        expect1("midrst_drained", S_DRAIN, 1'b1);
        expect1("midrst_filled", S_FILL, 1'b0);
        expect1("midrst_det", S_DET, 1'b0);
        expect1("midrst_door", S_DOOR, 1'b0);
        checkOutput();
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            expect1($sformatf("rewash_cyc_%0d", k), S_CYC, (k == 11));
            tick();
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();

        // Spin from empty drum
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            expect1($sformatf("spin_%0d", k), S_SPIN, (k >= 7));
            tick();
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        expect1("spin_motor_off", S_SPIN, 1'b0);
        tick();
        checkOutput();

        // Fault detection (expected only when the feature is built in)
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        expect1("fault_clean", S_FAULT, 1'b0);
        tick();
        checkOutput();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        expect1("fault_set", S_FAULT, FEN);
        expect1("fault_both_valves_level", S_DRAIN, 1'b1);
        tick();
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            expect1($sformatf("fault_hold_%0d", k), S_FAULT, FEN);
            tick();
            checkOutput();
        end
        rst = 1'b0;
        #2;
        expect1("fault_rst_clear", S_FAULT, 1'b0);
        expect1("fault_rst_drained", S_DRAIN, 1'b1);
        checkOutput();
        tick();
        rst = 1'b1;
        expect1("post_rst_drained", S_DRAIN, 1'b1);
        tick();
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
